multicycle_control: RTL and testbench

- Parametrised multi-cycle successor to the single-cycle main decoder for the RV32I subset: R-type (0110011), load (0000011), store (0100011), branch (1100011).
- Sequences each instruction through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK using a memory request/ready handshake.
- Adds a memory wait timeout, an illegal-opcode trap and a retired-instruction counter.
- Sits between the shared instruction/data memory port and the datapath (PC, IR, ALU, register file).

---
 rtl/ctrl_pkg.sv | 46 ++++
 rtl/ctrl_wait_timer.sv | 40 ++++
 rtl/multicycle_control.sv | 210 +++++++++++++++++++++
 tb/tb_multicycle_control.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_pkg
// Description : Shared types and constants for the multi-cycle RV32I
//               control unit: opcodes, FSM states, ALU classes, trap causes.
// Revision    : 1.0 - initial release
// ============================================================================
package ctrl_pkg;

    // RV32I major opcodes handled by this controller
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    // ALU operation classes
    localparam logic [1:0] ALU_ADD   = 2'd0;
    localparam logic [1:0] ALU_SUB   = 2'd1;
    localparam logic [1:0] ALU_FUNCT = 2'd2;

    // Trap cause codes
    localparam logic [1:0] TRAP_NONE    = 2'd0;
    localparam logic [1:0] TRAP_ILLEGAL = 2'd1;
    localparam logic [1:0] TRAP_TIMEOUT = 2'd2;

    // Controller states
    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_EXEC_R    = 4'd2,
        S_EXEC_ADDR = 4'd3,
        S_EXEC_BR   = 4'd4,
        S_MEM_RD    = 4'd5,
        S_MEM_WR    = 4'd6,
        S_WB_R      = 4'd7,
        S_WB_LD     = 4'd8,
        S_TRAP      = 4'd9
    } state_t;

    // True for states that hold a request on the shared memory port
    function automatic logic is_mem_state(input state_t s);
        return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
    endfunction

endpackage : ctrl_pkg
`default_nettype wire

// File: rtl/ctrl_wait_timer.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_wait_timer
// Description : Counts cycles a memory request is held without mem_ready and
//               flags a timeout when the count reaches MEM_TIMEOUT while the
//               request is still outstanding.
// Revision    : 1.0 - initial release
// ============================================================================
module ctrl_wait_timer #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_active,   // a memory request is being held this cycle
    input  logic i_ready,    // memory completes the request this cycle
    input  logic i_clear,    // controller changes state this cycle
    output logic o_timeout
);

    localparam int c_CW = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [c_CW-1:0] c_LIMIT = c_CW'(MEM_TIMEOUT);

    logic [c_CW-1:0] r_count;

    // A ready in the limit cycle wins over the timeout
    assign o_timeout = i_active && !i_ready && (r_count == c_LIMIT);

    // Wait counter: cleared on any state change or completion, else counts stalls
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clear || i_ready || !i_active) begin
            r_count <= '0;
        end else if (r_count != c_LIMIT) begin
            r_count <= r_count + c_CW'(1);
        end
    end

endmodule : ctrl_wait_timer
`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_control
// Description : Multi-cycle main controller for the RV32I R-type/load/store/
//               branch subset. Sequences FETCH/DECODE/EXECUTE/MEMORY/WB over
//               a shared memory port with a request/ready handshake, traps on
//               illegal opcodes or memory timeouts, and counts retirements.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_control
    import ctrl_pkg::*;
#(
    parameter int ALU_OP_WIDTH = 2,
    parameter int OPCODE_WIDTH = 7,
    parameter int MEM_TIMEOUT  = 15,
    parameter int CNT_WIDTH    = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [OPCODE_WIDTH-1:0] opcode,
    input  logic                    zero,
    input  logic                    mem_ready,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic                    i_or_d,
    output logic                    ir_write,
    output logic                    pc_write,
    output logic                    pc_src,
    output logic                    alu_src,
    output logic [ALU_OP_WIDTH-1:0] alu_op,
    output logic                    reg_write,
    output logic                    mem_to_reg,
    output logic                    retire,
    output logic [CNT_WIDTH-1:0]    instret,
    output logic                    trap,
    output logic [1:0]              trap_cause
);

    state_t               r_state;
    state_t               w_next;
    logic [CNT_WIDTH-1:0] r_instret;
    logic                 r_trap;
    logic [1:0]           r_trap_cause;

    logic       w_timeout;
    logic       w_mem_active;
    logic       w_state_change;
    logic [1:0] w_cause;
    logic [1:0] w_alu_op;

    logic w_mem_req, w_mem_we, w_i_or_d, w_ir_write, w_pc_write, w_pc_src;
    logic w_alu_src, w_reg_write, w_mem_to_reg, w_retire;

    assign w_mem_active   = is_mem_state(r_state);
    assign w_state_change = (w_next != r_state);

    ctrl_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_wait_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_active  (w_mem_active),
        .i_ready   (mem_ready),
        .i_clear   (w_state_change),
        .o_timeout (w_timeout)
    );

    // State register plus sticky trap status and retirement counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_FETCH;
            r_instret    <= '0;
            r_trap       <= 1'b0;
            r_trap_cause <= TRAP_NONE;
        end else begin
            r_state <= w_next;
            if (w_retire) begin
                r_instret <= r_instret + CNT_WIDTH'(1);
            end
            if ((w_next == S_TRAP) && (r_state != S_TRAP)) begin
                r_trap       <= 1'b1;
                r_trap_cause <= w_cause;
            end
        end
    end

    // Next-state and output decode; enables are forced low during reset
    always_comb begin
        w_next       = r_state;
        w_cause      = TRAP_NONE;
        w_mem_req    = 1'b0;
        w_mem_we     = 1'b0;
        w_i_or_d     = 1'b0;
        w_ir_write   = 1'b0;
        w_pc_write   = 1'b0;
        w_pc_src     = 1'b0;
        w_alu_src    = 1'b0;
        w_alu_op     = ALU_ADD;
        w_reg_write  = 1'b0;
        w_mem_to_reg = 1'b0;
        w_retire     = 1'b0;

        case (r_state)
            S_FETCH: begin
                w_mem_req = 1'b1;
                if (mem_ready) begin
                    w_ir_write = 1'b1;
                    w_pc_write = 1'b1;
                    w_next     = S_DECODE;
                end else if (w_timeout) begin
                    w_cause = TRAP_TIMEOUT;
                    w_next  = S_TRAP;
                end
            end
            S_DECODE: begin
                if (opcode == OPCODE_WIDTH'(OP_RTYPE)) begin
                    w_next = S_EXEC_R;
                end else if ((opcode == OPCODE_WIDTH'(OP_LOAD)) ||
                             (opcode == OPCODE_WIDTH'(OP_STORE))) begin
                    w_next = S_EXEC_ADDR;
                end else if (opcode == OPCODE_WIDTH'(OP_BRANCH)) begin
                    w_next = S_EXEC_BR;
                end else begin
                    w_cause = TRAP_ILLEGAL;
                    w_next  = S_TRAP;
                end
            end
            S_EXEC_R: begin
                w_alu_op = ALU_FUNCT;
                w_next   = S_WB_R;
            end
            S_EXEC_ADDR: begin
                w_alu_src = 1'b1;
                w_next    = (opcode == OPCODE_WIDTH'(OP_STORE)) ? S_MEM_WR : S_MEM_RD;
            end
            S_EXEC_BR: begin
                w_alu_op   = ALU_SUB;
                w_pc_src   = 1'b1;
                w_pc_write = zero;
                w_retire   = 1'b1;
                w_next     = S_FETCH;
            end
            S_MEM_RD: begin
                w_mem_req = 1'b1;
                w_i_or_d  = 1'b1;
                if (mem_ready) begin
                    w_next = S_WB_LD;
                end else if (w_timeout) begin
                    w_cause = TRAP_TIMEOUT;
                    w_next  = S_TRAP;
                end
            end
            S_MEM_WR: begin
                w_mem_req = 1'b1;
                w_i_or_d  = 1'b1;
                w_mem_we  = 1'b1;
                if (mem_ready) begin
                    w_retire = 1'b1;
                    w_next   = S_FETCH;
                end else if (w_timeout) begin
                    w_cause = TRAP_TIMEOUT;
                    w_next  = S_TRAP;
                end
            end
            S_WB_R: begin
                w_reg_write = 1'b1;
                w_retire    = 1'b1;
                w_next      = S_FETCH;
            end
            S_WB_LD: begin
                w_reg_write  = 1'b1;
                w_mem_to_reg = 1'b1;
                w_retire     = 1'b1;
                w_next       = S_FETCH;
            end
            S_TRAP: begin
                w_next = S_TRAP;
            end
            default: begin
                w_next = S_FETCH;
            end
        endcase

        if (!rst_n) begin
            w_mem_req   = 1'b0;
            w_mem_we    = 1'b0;
            w_ir_write  = 1'b0;
            w_pc_write  = 1'b0;
            w_reg_write = 1'b0;
            w_retire    = 1'b0;
        end
    end

    assign mem_req    = w_mem_req;
    assign mem_we     = w_mem_we;
    assign i_or_d     = w_i_or_d;
    assign ir_write   = w_ir_write;
    assign pc_write   = w_pc_write;
    assign pc_src     = w_pc_src;
    assign alu_src    = w_alu_src;
    assign alu_op     = ALU_OP_WIDTH'(w_alu_op);
    assign reg_write  = w_reg_write;
    assign mem_to_reg = w_mem_to_reg;
    assign retire     = w_retire;
    assign instret    = r_instret;
    assign trap       = r_trap;
    assign trap_cause = r_trap_cause;

endmodule : multicycle_control
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_control
// Description : Directed self-checking bench for multicycle_control
//               (MEM_TIMEOUT=15, CNT_WIDTH=4 to exercise counter wrap).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_control;

    localparam int c_TO = 15;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       mem_req, mem_we, i_or_d, ir_write, pc_write, pc_src;
    logic       alu_src, reg_write, mem_to_reg, retire, trap;
    logic [1:0] alu_op;
    logic [3:0] instret;
    logic [1:0] trap_cause;

    int total = 0;
    int bad   = 0;

    multicycle_control #(
        .ALU_OP_WIDTH (2),
        .OPCODE_WIDTH (7),
        .MEM_TIMEOUT  (c_TO),
        .CNT_WIDTH    (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode     (opcode),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .i_or_d     (i_or_d),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .pc_src     (pc_src),
        .alu_src    (alu_src),
        .alu_op     (alu_op),
        .reg_write  (reg_write),
        .mem_to_reg (mem_to_reg),
        .retire     (retire),
        .instret    (instret),
        .trap       (trap),
        .trap_cause (trap_cause)
    );

    always #5 clk = ~clk;

    // Advance one clock and settle just after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; opcode = 7'd0; zero = 1'b0; mem_ready = 1'b0;
        step(); step();

        // Reset cycle in FETCH with ready high: no IR/PC write allowed
        mem_ready = 1'b1; #1;
        chk("rst_ir_write", {31'd0, ir_write}, 32'd0);
        chk("rst_pc_write", {31'd0, pc_write}, 32'd0);
        chk("rst_instret",  {28'd0, instret},  32'd0);
        chk("rst_trap",     {31'd0, trap},     32'd0);
        chk("rst_cause",    {30'd0, trap_cause}, 32'd0);

        // R-type: FETCH(ready) -> DECODE -> EXEC_R -> WB_R
        rst_n = 1'b1; opcode = 7'b0110011; #1;
        chk("r_f_memreq",  {31'd0, mem_req},  32'd1);
        chk("r_f_iord",    {31'd0, i_or_d},   32'd0);
        chk("r_f_irwrite", {31'd0, ir_write}, 32'd1);
        chk("r_f_pcwrite", {31'd0, pc_write}, 32'd1);
        chk("r_f_pcsrc",   {31'd0, pc_src},   32'd0);
        step(); mem_ready = 1'b0; #1;
        chk("r_d_memreq",  {31'd0, mem_req},  32'd0);
        chk("r_d_irwrite", {31'd0, ir_write}, 32'd0);
        step();
        chk("r_e_aluop",   {30'd0, alu_op},   32'd2);
        chk("r_e_alusrc",  {31'd0, alu_src},  32'd0);
        chk("r_e_retire",  {31'd0, retire},   32'd0);
        step();
        chk("r_wb_regwr",  {31'd0, reg_write},  32'd1);
        chk("r_wb_m2r",    {31'd0, mem_to_reg}, 32'd0);
        chk("r_wb_retire", {31'd0, retire},     32'd1);
        step();
        chk("r_instret",   {28'd0, instret},  32'd1);
        chk("r_f2_memreq", {31'd0, mem_req},  32'd1);

        // Load with 3 wait cycles in MEM_RD
        opcode = 7'b0000011; mem_ready = 1'b1; #1;
        step(); mem_ready = 1'b0; #1;
        step();
        chk("ld_e_alusrc", {31'd0, alu_src}, 32'd1);
        chk("ld_e_aluop",  {30'd0, alu_op},  32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("ld_m_memreq", {31'd0, mem_req}, 32'd1);
            chk("ld_m_iord",   {31'd0, i_or_d},  32'd1);
            chk("ld_m_we",     {31'd0, mem_we},  32'd0);
        end
        step(); mem_ready = 1'b1; #1;
        chk("ld_m4_memreq", {31'd0, mem_req}, 32'd1);
        step(); mem_ready = 1'b0; #1;
        chk("ld_wb_regwr",  {31'd0, reg_write},  32'd1);
        chk("ld_wb_m2r",    {31'd0, mem_to_reg}, 32'd1);
        chk("ld_wb_retire", {31'd0, retire},     32'd1);
        chk("ld_wb_memreq", {31'd0, mem_req},    32'd0);
        step();
        chk("ld_instret",   {28'd0, instret},  32'd2);

        // Branch taken (zero=1) then not taken (zero=0)
        opcode = 7'b1100011; mem_ready = 1'b1; #1;
        step(); mem_ready = 1'b0; #1;
        step(); zero = 1'b1; #1;
        chk("br1_pcwrite", {31'd0, pc_write}, 32'd1);
        chk("br1_pcsrc",   {31'd0, pc_src},   32'd1);
        chk("br1_aluop",   {30'd0, alu_op},   32'd1);
        chk("br1_retire",  {31'd0, retire},   32'd1);
        step(); mem_ready = 1'b1; #1;
        chk("br1_instret", {28'd0, instret},  32'd3);
        step(); mem_ready = 1'b0; #1;
        step(); zero = 1'b0; #1;
        chk("br2_pcwrite", {31'd0, pc_write}, 32'd0);
        chk("br2_pcsrc",   {31'd0, pc_src},   32'd1);
        chk("br2_retire",  {31'd0, retire},   32'd1);
        step();
        chk("br2_instret", {28'd0, instret},  32'd4);

        // Illegal opcode traps after DECODE
        opcode = 7'b1111111; mem_ready = 1'b1; #1;
        step(); mem_ready = 1'b0; #1;
        step(); mem_ready = 1'b1; #1;
        chk("ill_trap",    {31'd0, trap},       32'd1);
        chk("ill_cause",   {30'd0, trap_cause}, 32'd1);
        chk("ill_memreq",  {31'd0, mem_req},    32'd0);
        chk("ill_irwrite", {31'd0, ir_write},   32'd0);
        step();
        chk("ill_hold_trap",   {31'd0, trap},    32'd1);
        chk("ill_hold_memreq", {31'd0, mem_req}, 32'd0);
        rst_n = 1'b0; mem_ready = 1'b0;
        step();
        chk("ill_rst_trap",    {31'd0, trap},       32'd0);
        chk("ill_rst_cause",   {30'd0, trap_cause}, 32'd0);
        chk("ill_rst_instret", {28'd0, instret},    32'd0);

        // FETCH timeout: 15 stall cycles, then limit cycle without ready
        rst_n = 1'b1; #1;
        chk("to_f_memreq", {31'd0, mem_req}, 32'd1);
        for (int i = 0; i < c_TO; i++) begin
            step();
        end
        chk("to_limit_trap", {31'd0, trap}, 32'd0);
        step();
        chk("to_trap",   {31'd0, trap},       32'd1);
        chk("to_cause",  {30'd0, trap_cause}, 32'd2);
        chk("to_memreq", {31'd0, mem_req},    32'd0);

        // Same stall, ready arrives exactly on the limit cycle
        rst_n = 1'b0;
        step();
        rst_n = 1'b1; opcode = 7'b0100011; #1;
        for (int i = 0; i < c_TO; i++) begin
            step();
        end
        mem_ready = 1'b1; #1;
        chk("lim_irwrite", {31'd0, ir_write}, 32'd1);
        step();
        chk("lim_trap",    {31'd0, trap},    32'd0);
        chk("lim_decode_memreq", {31'd0, mem_req}, 32'd0);

        // 17 stores with a 4-bit counter: wraps to 1
        step(); step();
        chk("st_memwe",  {31'd0, mem_we},  32'd1);
        chk("st_iord",   {31'd0, i_or_d},  32'd1);
        chk("st_retire", {31'd0, retire},  32'd1);
        step();
        chk("st1_instret", {28'd0, instret}, 32'd1);
        for (int n = 2; n <= 17; n++) begin
            step(); step(); step(); step();
            if (n == 16) begin
                chk("st16_instret", {28'd0, instret}, 32'd0);
            end
        end
        chk("st17_instret", {28'd0, instret}, 32'd1);

        // Reset asserted in MEM_WR with ready high: no write, no retire
        step(); step(); step();
        rst_n = 1'b0; #1;
        chk("rstwr_memwe",  {31'd0, mem_we}, 32'd0);
        chk("rstwr_retire", {31'd0, retire}, 32'd0);
        step();
        rst_n = 1'b1; mem_ready = 1'b0; #1;
        chk("rstwr_fetch_memreq", {31'd0, mem_req}, 32'd1);
        chk("rstwr_fetch_iord",   {31'd0, i_or_d},  32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_multicycle_control
`default_nettype wire
